uart_rx_ctrl: RTL and testbench

- Receive-side controller between uart_rx (valid/ready byte stream) and the debug-console MMIO register block.
- Buffers received bytes in a show-ahead FIFO and never stalls the receiver.
- Detects and counts overruns, raises a line-idle timeout after a programmable number of character times, and generates one level-sensitive interrupt for the console driver.

---
 rtl/uart_rx_ctrl.sv | 127 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side console controller: show-ahead byte FIFO fed by uart_rx,
// with overrun tracking, line-idle timeout and a single level interrupt.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int CLK_FREQ_HZ = 300000000,
    parameter int BAUD_RATE   = 115200,
    parameter int IDLE_CHARS  = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [DATA_WIDTH-1:0]           i_rx_data,
    input  logic                            i_rx_valid,
    output logic                            o_rx_ready,
    input  logic                            i_pop,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_empty,
    output logic                            o_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
    input  logic                            i_flush,
    input  logic                            i_irq_en,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0] i_irq_thresh,
    input  logic                            i_clr_overrun,
    output logic                            o_overrun,
    output logic [7:0]                      o_drop_count,
    output logic                            o_timeout,
    output logic                            o_irq
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0]   TIMEOUT_CYCLES = 32'(IDLE_CHARS * 10 * (CLK_FREQ_HZ / BAUD_RATE));
    localparam logic [LW-1:0] DEPTH_L        = LW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [31:0]           timer_q, timer_d;
    logic                  timeout_q, timeout_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic empty, full, push, pop, drop;

    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH_L);
    assign push  = i_rx_valid && !i_flush && (!full || i_pop);
    assign drop  = i_rx_valid && full && !i_pop && !i_flush;
    assign pop   = i_pop && !empty && !i_flush;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;

        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push) level_d = level_q - 1'b1;
        end

        // Timer only runs while bytes sit untouched in the FIFO.
        if (push || pop || i_flush || empty) begin
            timer_d = '0;
        end else if (timer_q < TIMEOUT_CYCLES) begin
            timer_d = timer_q + 32'd1;
        end

        if (push || pop || i_flush) begin
            timeout_d = 1'b0;
        end else if (timer_q == TIMEOUT_CYCLES && !empty) begin
            timeout_d = 1'b1;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end

        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; o_data masks it to zero whenever empty.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_rx_data;
    end

    assign o_rx_ready   = 1'b1;
    assign o_data       = empty ? '0 : mem_q[rd_ptr_q];
    assign o_empty      = empty;
    assign o_full       = full;
    assign o_level      = level_q;
    assign o_overrun    = overrun_q;
    assign o_drop_count = drop_cnt_q;
    assign o_timeout    = timeout_q;
    assign o_irq        = i_irq_en && (((i_irq_thresh != '0) && (level_q >= i_irq_thresh))
                                       || timeout_q || overrun_q);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: vector table for FIFO/overrun/flush behaviour, a data
// scoreboard on every pop, and hand sequences for timeout, irq and async reset.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid, pop, flush, irq_en, clr;
    logic [2:0] irq_thresh;
    logic       rx_ready, empty, full, overrun, timeout, irq;
    logic [7:0] data, drop_count;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    uart_rx_ctrl #(
        .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .CLK_FREQ_HZ(1000),
        .BAUD_RATE(100), .IDLE_CHARS(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready), .i_pop(pop), .o_data(data), .o_empty(empty),
        .o_full(full), .o_level(level), .i_flush(flush), .i_irq_en(irq_en),
        .i_irq_thresh(irq_thresh), .i_clr_overrun(clr), .o_overrun(overrun),
        .o_drop_count(drop_count), .o_timeout(timeout), .o_irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] d;
        logic       pop;
        logic       flush;
        logic       clr;
        int         lvl;
        logic [7:0] dat;
        logic       emp;
        logic       ful;
        logic       ov;
        int         dc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t V(logic vld, logic [7:0] d, logic p, logic f, logic c,
                               int lvl, logic [7:0] dat, logic emp, logic ful,
                               logic ov, int dc);
        vec_t v;
        v.vld = vld; v.d = d; v.pop = p; v.flush = f; v.clr = c;
        v.lvl = lvl; v.dat = dat; v.emp = emp; v.ful = ful; v.ov = ov; v.dc = dc;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // One clock of stimulus; the scoreboard checks the head on every pop.
    task automatic cyc(input logic vld, input logic [7:0] d, input logic p,
                       input logic f, input logic c);
        @(negedge clk);
        rx_valid = vld; rx_data = d; pop = p; flush = f; clr = c;
        if (f) begin
            sb.delete();
        end else begin
            if (p && sb.size() > 0) begin
                chk("sb_head", int'(data), int'(sb[0]));
                void'(sb.pop_front());
            end
            if (vld && sb.size() < DEPTH) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0; pop = 1'b0; flush = 1'b0; clr = 1'b0;
        chk("sb_level", int'(level), sb.size());
    endtask

    initial begin
        int n;
        logic seen;

        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; pop = 1'b0; flush = 1'b0;
        clr = 1'b0; irq_en = 1'b0; irq_thresh = '0;

        // Inclusive of read-order, overrun, full+pop, empty-pop, flush and clr/drop race.
        vq.push_back(V(1, 8'h41, 0, 0, 0, 1, 8'h41, 0, 0, 0, 0));
        vq.push_back(V(1, 8'h42, 0, 0, 0, 2, 8'h41, 0, 0, 0, 0));
        vq.push_back(V(1, 8'h43, 0, 0, 0, 3, 8'h41, 0, 0, 0, 0));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 2, 8'h42, 0, 0, 0, 0));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 1, 8'h43, 0, 0, 0, 0));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0));
        vq.push_back(V(1, 8'h10, 0, 0, 0, 1, 8'h10, 0, 0, 0, 0));
        vq.push_back(V(1, 8'h11, 0, 0, 0, 2, 8'h10, 0, 0, 0, 0));
        vq.push_back(V(1, 8'h12, 0, 0, 0, 3, 8'h10, 0, 0, 0, 0));
        vq.push_back(V(1, 8'h13, 0, 0, 0, 4, 8'h10, 0, 1, 0, 0));
        vq.push_back(V(1, 8'h14, 0, 0, 0, 4, 8'h10, 0, 1, 1, 1));
        vq.push_back(V(1, 8'h15, 0, 0, 0, 4, 8'h10, 0, 1, 1, 2));
        vq.push_back(V(0, 8'h00, 0, 0, 1, 4, 8'h10, 0, 1, 0, 2));
        vq.push_back(V(1, 8'h99, 1, 0, 0, 4, 8'h11, 0, 1, 0, 2));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 3, 8'h12, 0, 0, 0, 2));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 2, 8'h13, 0, 0, 0, 2));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 1, 8'h99, 0, 0, 0, 2));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 2));
        vq.push_back(V(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 2));
        vq.push_back(V(1, 8'h21, 0, 0, 0, 1, 8'h21, 0, 0, 0, 2));
        vq.push_back(V(1, 8'h22, 0, 0, 0, 2, 8'h21, 0, 0, 0, 2));
        vq.push_back(V(1, 8'h23, 0, 0, 0, 3, 8'h21, 0, 0, 0, 2));
        vq.push_back(V(1, 8'h24, 0, 1, 0, 0, 8'h00, 1, 0, 0, 2));
        vq.push_back(V(1, 8'h30, 0, 0, 0, 1, 8'h30, 0, 0, 0, 2));
        vq.push_back(V(1, 8'h31, 0, 0, 0, 2, 8'h30, 0, 0, 0, 2));
        vq.push_back(V(1, 8'h32, 0, 0, 0, 3, 8'h30, 0, 0, 0, 2));
        vq.push_back(V(1, 8'h33, 0, 0, 0, 4, 8'h30, 0, 1, 0, 2));
        vq.push_back(V(1, 8'h34, 0, 0, 1, 4, 8'h30, 0, 1, 1, 3));
        vq.push_back(V(0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 1, 3));
        vq.push_back(V(0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 0, 3));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_irq", int'(irq), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rx_ready", int'(rx_ready), 1);

        foreach (vq[i]) begin
            cyc(vq[i].vld, vq[i].d, vq[i].pop, vq[i].flush, vq[i].clr);
            chk($sformatf("v%0d_level", i), int'(level), vq[i].lvl);
            chk($sformatf("v%0d_data", i), int'(data), int'(vq[i].dat));
            chk($sformatf("v%0d_empty", i), int'(empty), int'(vq[i].emp));
            chk($sformatf("v%0d_full", i), int'(full), int'(vq[i].ful));
            chk($sformatf("v%0d_overrun", i), int'(overrun), int'(vq[i].ov));
            chk($sformatf("v%0d_drop", i), int'(drop_count), vq[i].dc);
        end

        // Idle timeout: expected 201 edges after the push edge.
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!timeout && n <= 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_latency", n, 201);
        irq_en = 1'b1; irq_thresh = 3'd0;
        #1;
        chk("irq_timeout", int'(irq), 1);
        irq_en = 1'b0;
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("timeout_clr_pop", int'(timeout), 0);
        seen = 1'b0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            seen = seen | timeout;
        end
        chk("timeout_empty_idle", int'(seen), 0);

        // Level interrupt threshold.
        irq_en = 1'b1; irq_thresh = 3'd2;
        cyc(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        chk("irq_lvl1", int'(irq), 0);
        cyc(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        chk("irq_lvl2", int'(irq), 1);
        irq_thresh = 3'd0;
        #1;
        chk("irq_thresh0", int'(irq), 0);

        // Asynchronous reset mid-timeout, between clock edges.
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
        repeat (150) @(posedge clk);
        #1;
        chk("pre_rst_level", int'(level), 1);
        chk("pre_rst_timeout", int'(timeout), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_data", int'(data), 0);
        chk("arst_drop", int'(drop_count), 0);
        chk("arst_timeout", int'(timeout), 0);
        chk("arst_overrun", int'(overrun), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
